// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states and the default width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_INC  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_MUL  = 4'b0011,
        OP_DIV  = 4'b0100,
        OP_REM  = 4'b0101,
        OP_AND  = 4'b0110,
        OP_OR   = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_SHL  = 4'b1001,
        OP_SHR  = 4'b1010,
        OP_USHR = 4'b1011,
        OP_NEG  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } alu_state_e;

    function automatic logic is_multicycle(input alu_op_e op);
        return op inside {OP_MUL, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_divide(input alu_op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mc_alu_div.sv
// Iterative restoring divider on operand magnitudes; signs are reapplied on the final step.
module mc_alu_div
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             neg_quo;
    logic             neg_rem;
    logic             zero_q;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // quo_q starts as the dividend magnitude and fills with quotient bits from the right
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvsr_q};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            zero_q  <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_q  <= divisor[WIDTH-1] ? -divisor : divisor;
            neg_quo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem <= dividend[WIDTH-1];
            zero_q  <= (divisor == '0);
            busy    <= 1'b1;
            cnt     <= '0;
        end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // Results are taken from the final step combinationally so the caller can latch them on done.
    always_comb begin
        done      = busy && (cnt == CNT_W'(WIDTH - 1));
        div_zero  = zero_q;
        quotient  = zero_q ? '0 : (neg_quo ? -quo_next : quo_next);
        remainder = zero_q ? '0 : (neg_rem ? -rem_next : rem_next);
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ops, iterative signed shift-add multiplier, divider sub-module.
module mc_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       op_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    alu_state_e state;
    alu_state_e state_next;
    alu_op_e    op_in;
    alu_op_e    op_q;

    logic             accept;
    logic             last;
    logic             compute_end;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] quick;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_dz;

    mc_alu_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_divide(op_in)),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div_zero  (div_dz)
    );

    always_comb begin
        op_in       = alu_op_e'(op_select);
        accept      = (state == ST_IDLE) && in_valid;
        last        = (state == ST_COMPUTE) && (cnt == CNT_W'(WIDTH - 1));
        compute_end = (state == ST_COMPUTE) && (is_divide(op_q) ? div_done : last);
        shamt       = operand_b[CNT_W-1:0];
    end

    always_comb begin
        quick = '0;
        case (op_in)
            OP_INC:  quick = operand_a + WIDTH'(1);
            OP_ADD:  quick = operand_a + operand_b;
            OP_SUB:  quick = operand_a - operand_b;
            OP_AND:  quick = operand_a & operand_b;
            OP_OR:   quick = operand_a | operand_b;
            OP_XOR:  quick = operand_a ^ operand_b;
            OP_SHL:  quick = operand_a << shamt;
            OP_SHR:  quick = WIDTH'($signed(operand_a) >>> shamt);
            OP_USHR: quick = operand_a >> shamt;
            OP_NEG:  quick = -operand_a;
            default: quick = '0;
        endcase
    end

    // The multiplier's MSB carries weight -2^(WIDTH-1), so the final partial product is subtracted.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        acc_next = last ? (acc - addend) : (acc + addend);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (in_valid) state_next = is_multicycle(op_in) ? ST_COMPUTE : ST_DONE;
            ST_COMPUTE: if (compute_end) state_next = ST_DONE;
            ST_DONE:    if (out_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_INC;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            op_q   <= op_in;
            cnt    <= '0;
            mcand  <= {{WIDTH{operand_a[WIDTH-1]}}, operand_a};
            mplier <= operand_b;
            acc    <= '0;
            if (!is_multicycle(op_in)) begin
                result_lo <= quick;
                result_hi <= '0;
                div_zero  <= 1'b0;
            end
        end else if (state == ST_COMPUTE) begin
            cnt    <= cnt + CNT_W'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
            if (compute_end) begin
                cnt <= '0;
                if (op_q == OP_MUL) begin
                    {result_hi, result_lo} <= acc_next;
                    div_zero               <= 1'b0;
                end else begin
                    result_hi <= '0;
                    result_lo <= (op_q == OP_DIV) ? div_quo : div_rem;
                    div_zero  <= div_dz;
                end
            end
        end
    end

endmodule
